// File: rtl/bram_stream_reader_pkg.sv
// Shared constants for the BRAM stream reader: output buffer geometry and
// the read-pipeline depth that the issue throttle has to account for.
package bram_stream_reader_pkg;

  localparam int unsigned FIFO_DEPTH   = 4;
  localparam int unsigned FIFO_CW      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned MAX_INFLIGHT = 2;
  // Wide enough for fifo_count + inflight at their worst case.
  localparam int unsigned OCC_W        = $clog2(FIFO_DEPTH + MAX_INFLIGHT + 1);

endpackage

// File: rtl/bram_stream_reader_if.sv
// Bundle of the reader's burst-request, memory-port and stream signals.
//   start/base/len : burst request (sampled by the reader in IDLE)
//   addr_read      : registered read address to the synchronous memory
//   data_read      : memory data, valid one cycle after addr_read
//   out_data/out_valid/out_ready : output stream handshake
//   busy/done      : burst status
// master drives requests, memory data and out_ready; slave is the reader.
interface bram_stream_reader_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 256
);
  localparam int unsigned ADDRW = $clog2(DEPTH);

  logic             start;
  logic [ADDRW-1:0] base;
  logic [ADDRW:0]   len;
  logic [ADDRW-1:0] addr_read;
  logic [WIDTH-1:0] data_read;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;

  modport master (
    output start, base, len, data_read, out_ready,
    input  addr_read, out_data, out_valid, busy, done
  );

  modport slave (
    input  start, base, len, data_read, out_ready,
    output addr_read, out_data, out_valid, busy, done
  );

endinterface

// File: rtl/bram_stream_reader_fifo_reg.sv
// fifo_reg: small shift-register FIFO; the head always sits in entry 0 so
// the output data comes straight from a register.
//   clk, rst       : clock, async active-high reset
//   push/push_data : write an entry (accepted when not full, or when popping)
//   pop            : remove the head (ignored when empty)
//   head/valid     : head entry and not-empty flag
//   count          : number of stored entries
module fifo_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             pop_ok;
  logic             push_ok;
  logic [CW-1:0]    count_nxt;
  logic [AW-1:0]    wr_idx;

  // A simultaneous pop shifts everything down, so the write slot moves too.
  always_comb begin
    pop_ok    = pop && valid;
    push_ok   = push && ((count != CW'(DEPTH)) || pop_ok);
    count_nxt = count + CW'(push_ok) - CW'(pop_ok);
    wr_idx    = AW'(count - CW'(pop_ok));
  end

  assign head = mem[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      count <= '0;
      valid <= 1'b0;
    end else begin
      if (pop_ok) begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) mem[i] <= mem[i+1];
      end
      if (push_ok) mem[wr_idx] <= push_data;
      count <= count_nxt;
      valid <= (count_nxt != '0);
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: reads a burst of len words starting at base from a
// synchronous-read memory and streams them out in address order through a
// 4-entry buffer, throttling address issue so backpressure never drops data.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of bram_stream_reader_if (request, memory port,
//              output stream, busy/done)
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  bram_stream_reader_if.slave  bus
);

  localparam int unsigned ADDRW = $clog2(DEPTH);
  localparam int unsigned LENW  = ADDRW + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t             state;
  logic [ADDRW-1:0]   addr_q;
  logic [LENW-1:0]    len_q;
  logic [LENW-1:0]    issued;
  logic [LENW-1:0]    xfers;
  logic               iss_v0;   // addr_read holds a fresh burst address
  logic               iss_v1;   // data_read holds that address's word
  logic               busy_q;
  logic               done_q;

  logic [FIFO_CW-1:0] fifo_count;
  logic               fifo_valid;
  logic [WIDTH-1:0]   fifo_head;
  logic               transfer;
  logic [OCC_W-1:0]   occupancy;
  logic               can_issue;

  assign transfer  = fifo_valid && bus.out_ready;
  // Every in-flight read needs a guaranteed slot in the buffer.
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(iss_v0) + OCC_W'(iss_v1);
  assign can_issue = occupancy < OCC_W'(FIFO_DEPTH);

  fifo_reg #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (iss_v1),
    .push_data (bus.data_read),
    .pop       (transfer),
    .head      (fifo_head),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  assign bus.addr_read = addr_q;
  assign bus.out_data  = fifo_head;
  assign bus.out_valid = fifo_valid;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  // Burst control, address issue and read-pipeline tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
      len_q  <= '0;
      issued <= '0;
      xfers  <= '0;
      iss_v0 <= 1'b0;
      iss_v1 <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      iss_v1 <= iss_v0;
      iss_v0 <= 1'b0;
      done_q <= 1'b0;
      if (transfer) xfers <= xfers + LENW'(1);

      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.len == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              // The start edge itself issues the first address.
              state  <= READ;
              len_q  <= bus.len;
              addr_q <= bus.base;
              iss_v0 <= 1'b1;
              issued <= LENW'(1);
              xfers  <= '0;
              busy_q <= 1'b1;
            end
          end
        end
        READ: begin
          if (issued == len_q) begin
            state <= DRAIN;
          end else if (can_issue) begin
            addr_q <= addr_q + ADDRW'(1);
            iss_v0 <= 1'b1;
            issued <= issued + LENW'(1);
          end
        end
        DRAIN: begin
          if (transfer && (xfers == len_q - LENW'(1))) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader: expected words are queued when a
// burst is launched and a negedge monitor pops and compares every transfer.
module tb_bram_stream_reader;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;

  logic clk;
  logic rst;

  bram_stream_reader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  bram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous-read memory, mem[i] = i.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) bus.data_read <= mem[bus.addr_read];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int xfer_cnt = 0;
  int ready_mode = 0;
  logic [WIDTH-1:0] exp_q [$];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // out_ready pattern generator: 0 = always, 1 = 1,0,0,1 repeating, 2 = random.
  initial begin
    int ph;
    ph = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: bus.out_ready = 1'b1;
        1: begin
          bus.out_ready = (ph == 0) || (ph == 3);
          ph = (ph + 1) % 4;
        end
        default: bus.out_ready = ($urandom % 4) != 0;
      endcase
    end
  end

  // Monitor: compares each transfer against the scoreboard and checks hold.
  initial begin
    logic             stall;
    logic [WIDTH-1:0] held;
    logic [WIDTH-1:0] exp;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("stall_valid", bus.out_valid, 1);
          check("stall_data", bus.out_data, held);
        end
        if (bus.done) done_cnt++;
        if (bus.out_valid && bus.out_ready) begin
          xfer_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %0d, expected no word", bus.out_data);
          end else begin
            exp = exp_q.pop_front();
            check("word", bus.out_data, exp);
          end
        end
        stall = bus.out_valid && !bus.out_ready;
        held  = bus.out_data;
      end
    end
  end

  // Launch a burst, queue its expected words, and wait for completion.
  task automatic run_burst(input int b, input int l, input int mode,
                           input bit lat, input bit poke);
    int cyc;
    int bubbles;
    ready_mode = mode;
    for (int i = 0; i < l; i++) exp_q.push_back(WIDTH'((b + i) % DEPTH));
    bus.start = 1'b1;
    bus.base  = 4'(b);
    bus.len   = 5'(l);
    tick();
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, int'(l != 0));
    if (l == 0) begin
      check("zero_len_done", bus.done, 1);
      check("zero_len_valid", bus.out_valid, 0);
    end
    if (lat && l > 0) begin
      check("lat_edge0", bus.out_valid, 0);
      tick();
      check("lat_edge1", bus.out_valid, 0);
      tick();
      check("lat_edge2", bus.out_valid, 1);
      bubbles = 0;
      for (int k = 1; k < l; k++) begin
        tick();
        if (!bus.out_valid) bubbles++;
      end
      check("bubbles", bubbles, 0);
      tick();
      check("done_after_last", bus.done, 1);
    end
    cyc = 0;
    while (!bus.done && cyc < 400) begin
      tick();
      cyc++;
      if (poke && cyc == 3) begin
        bus.start = 1'b1;
        bus.base  = 4'd9;
        bus.len   = 5'd3;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check("done_seen", bus.done, 1);
    check("all_words_out", exp_q.size(), 0);
    check("busy_at_done", bus.busy, 0);
    tick();
    check("done_one_cycle", bus.done, 0);
    check("idle_no_valid", bus.out_valid, 0);
  endtask

  initial begin
    int x0;
    int d0;
    int cyc;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = WIDTH'(i);
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.base  = '0;
    bus.len   = '0;
    repeat (2) tick();
    check("rst_addr", bus.addr_read, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    rst = 1'b0;
    tick();

    run_burst(3, 5, 0, 1'b1, 1'b0);    // basic burst with latency/throughput
    run_burst(14, 4, 0, 1'b1, 1'b0);   // address wrap
    run_burst(0, 8, 1, 1'b0, 1'b1);    // backpressure, start ignored mid-burst
    run_burst(5, 0, 0, 1'b0, 1'b0);    // zero length
    run_burst(5, 16, 0, 1'b1, 1'b0);   // full memory

    // Reset after the third transfer of a 10-word burst.
    ready_mode = 0;
    for (int i = 0; i < 10; i++) exp_q.push_back(WIDTH'(i));
    bus.start = 1'b1;
    bus.base  = 4'd0;
    bus.len   = 5'd10;
    tick();
    bus.start = 1'b0;
    x0  = xfer_cnt;
    cyc = 0;
    while ((xfer_cnt - x0) < 3 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("abort_three_xfers", xfer_cnt - x0, 3);
    rst = 1'b1;
    #1;
    check("abort_addr", bus.addr_read, 0);
    check("abort_valid", bus.out_valid, 0);
    check("abort_data", bus.out_data, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    exp_q.delete();
    d0 = done_cnt;
    repeat (2) tick();
    rst = 1'b0;
    repeat (6) tick();
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_no_stale", bus.out_valid, 0);
    run_burst(2, 2, 0, 1'b0, 1'b0);

    // Randomized bursts against the address-order model.
    for (int n = 0; n < 12; n++) begin
      run_burst(int'($urandom % DEPTH), int'($urandom % (DEPTH + 1)), 2, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
